// File: rtl/proc_scheduler_pkg.sv
// Shared definitions for the process scheduler: FSM states, page field layout
// and default table/time-slice sizes.
package proc_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_RESTORE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SAVE    = 3'd4
    } sched_state_e;

    localparam int PAGE_BASE_MSB = 31;
    localparam int PAGE_BASE_LSB = 16;
    localparam int PAGE_END_MSB  = 15;
    localparam int PAGE_END_LSB  = 0;

    localparam int DEFAULT_NPROC   = 8;
    localparam int DEFAULT_QUANTUM = 64;

    function automatic logic [15:0] page_base(input logic [31:0] page);
        return page[PAGE_BASE_MSB:PAGE_BASE_LSB];
    endfunction

    function automatic logic [15:0] page_end(input logic [31:0] page);
        return page[PAGE_END_MSB:PAGE_END_LSB];
    endfunction

endpackage

// File: rtl/proc_scheduler_rr_pick.sv
// Combinational round-robin selector: first set bit of mask_i at or after
// start_i, wrapping at N.
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] pid_o,
    output logic         found_o
);

    logic [W-1:0] idx;

    // Walk offsets from far to near so the closest hit is written last.
    always_comb begin
        pid_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(start_i) + i) % N);
            if (mask_i[idx]) begin
                pid_o   = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_scheduler.sv
// Process-table scheduler: allocates pages into slots and time-shares the CPU
// round-robin. Define SCHED_PREEMPT_EN for quantum preemption; default is cooperative.
module proc_scheduler
    import proc_scheduler_pkg::*;
#(
    parameter int  NPROC   = DEFAULT_NPROC,
    parameter int  QUANTUM = DEFAULT_QUANTUM,
    localparam int PID_W   = $clog2(NPROC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en_i,
    input  logic             page_wr_i,
    input  logic [31:0]      page_in_i,
    input  logic             proc_exit_i,
    input  logic             yield_i,
    input  logic             ctx_ack_i,
    input  logic             save_ack_i,
    input  logic [31:0]      cpu_pc_i,
    output logic             ctx_valid_o,
    output logic [PID_W-1:0] ctx_pid_o,
    output logic [31:0]      ctx_pc_o,
    output logic             save_req_o,
    output logic             running_o,
    output logic [PID_W:0]   proc_count_o,
    output logic             page_drop_o,
    output logic [15:0]      ctx_base_o,
    output logic [15:0]      ctx_limit_o,
    output logic [2:0]       state_o
);

    localparam int CW = PID_W + 1;

    sched_state_e     state_q, state_d;
    logic [PID_W-1:0] ctx_pid_q, ctx_pid_d;
    logic [NPROC-1:0] valid_q;
    logic [15:0]      base_q     [NPROC];
    logic [15:0]      limit_q    [NPROC];
    logic [31:0]      saved_pc_q [NPROC];
    logic             page_drop_q;
    logic [CW-1:0]    count;

    logic [PID_W-1:0] rr_start, sel_pid, free_pid;
    logic             sel_found, free_found;
    logic             exit_now, save_now, expired, active;

    assign rr_start = (ctx_pid_q == PID_W'(NPROC - 1)) ? '0 : ctx_pid_q + 1'b1;

    rr_pick #(.N(NPROC), .W(PID_W)) u_sel_pick (
        .mask_i (valid_q),
        .start_i(rr_start),
        .pid_o  (sel_pid),
        .found_o(sel_found)
    );

    rr_pick #(.N(NPROC), .W(PID_W)) u_free_pick (
        .mask_i (~valid_q),
        .start_i({PID_W{1'b0}}),
        .pid_o  (free_pid),
        .found_o(free_found)
    );

`ifdef SCHED_PREEMPT_EN
    localparam int QW = $clog2(QUANTUM);
    logic [QW-1:0] quant_q, quant_d;

    always_comb begin
        quant_d = quant_q;
        if (state_q == ST_RESTORE && ctx_ack_i) begin
            quant_d = QW'(QUANTUM - 1);
        end else if (state_q == ST_RUN && quant_q != '0) begin
            quant_d = quant_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) quant_q <= '0;
        else       quant_q <= quant_d;
    end

    assign expired = (quant_q == '0);
`else
    // Cooperative build: QUANTUM is kept only so both builds share one interface.
    logic [31:0] quantum_unused;
    assign quantum_unused = 32'(QUANTUM);
    assign expired        = 1'b0;
`endif

    // Handshakes: ctx_valid_o holds ctx_pid_o/ctx_pc_o stable until ctx_ack_i;
    // save_req_o holds until save_ack_i, which qualifies cpu_pc_i that cycle.
    always_comb begin
        state_d   = state_q;
        ctx_pid_d = ctx_pid_q;
        exit_now  = 1'b0;
        save_now  = 1'b0;
        case (state_q)
            ST_IDLE: if (run_en_i && valid_q != '0) state_d = ST_SELECT;
            ST_SELECT: begin
                if (!run_en_i || !sel_found) begin
                    state_d = ST_IDLE;
                end else begin
                    ctx_pid_d = sel_pid;
                    state_d   = ST_RESTORE;
                end
            end
            ST_RESTORE: if (ctx_ack_i) state_d = ST_RUN;
            ST_RUN: begin
                if (proc_exit_i) begin
                    exit_now = 1'b1;
                    state_d  = ST_SELECT;
                end else if (yield_i || expired) begin
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                if (save_ack_i) begin
                    save_now = 1'b1;
                    state_d  = ST_SELECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ctx_pid_q   <= PID_W'(NPROC - 1);
            valid_q     <= '0;
            page_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctx_pid_q   <= ctx_pid_d;
            page_drop_q <= page_wr_i && !free_found;
            if (page_wr_i && free_found) valid_q[free_pid] <= 1'b1;
            // An exiting slot is still valid this cycle, so allocation never targets it.
            if (exit_now) valid_q[ctx_pid_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (page_wr_i && free_found) begin
            base_q[free_pid]     <= page_base(page_in_i);
            limit_q[free_pid]    <= page_end(page_in_i);
            saved_pc_q[free_pid] <= {16'h0000, page_base(page_in_i)};
        end
        if (save_now) saved_pc_q[ctx_pid_q] <= cpu_pc_i;
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NPROC; i++) count = count + CW'(valid_q[i]);
    end

    assign active       = (state_q == ST_RESTORE) || (state_q == ST_RUN) || (state_q == ST_SAVE);
    assign ctx_valid_o  = (state_q == ST_RESTORE);
    assign running_o    = (state_q == ST_RUN);
    assign save_req_o   = (state_q == ST_SAVE);
    assign ctx_pid_o    = active ? ctx_pid_q : '0;
    assign ctx_pc_o     = ctx_valid_o ? saved_pc_q[ctx_pid_q] : '0;
    assign ctx_base_o   = active ? base_q[ctx_pid_q] : '0;
    assign ctx_limit_o  = active ? limit_q[ctx_pid_q] : '0;
    assign proc_count_o = count;
    assign page_drop_o  = page_drop_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Self-checking bench for proc_scheduler; adapts quantum checks to SCHED_PREEMPT_EN.
module tb_proc_scheduler;
    localparam int NPROC   = 8;
    localparam int QUANTUM = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en_i, page_wr_i, proc_exit_i, yield_i, ctx_ack_i, save_ack_i;
    logic [31:0] page_in_i, cpu_pc_i;
    logic        ctx_valid_o, save_req_o, running_o, page_drop_o;
    logic [2:0]  ctx_pid_o;
    logic [31:0] ctx_pc_o;
    logic [3:0]  proc_count_o;
    logic [15:0] ctx_base_o, ctx_limit_o;
    logic [2:0]  state_o;

    proc_scheduler #(.NPROC(NPROC), .QUANTUM(QUANTUM)) dut (
        .clk(clk), .reset(reset), .run_en_i(run_en_i), .page_wr_i(page_wr_i),
        .page_in_i(page_in_i), .proc_exit_i(proc_exit_i), .yield_i(yield_i),
        .ctx_ack_i(ctx_ack_i), .save_ack_i(save_ack_i), .cpu_pc_i(cpu_pc_i),
        .ctx_valid_o(ctx_valid_o), .ctx_pid_o(ctx_pid_o), .ctx_pc_o(ctx_pc_o),
        .save_req_o(save_req_o), .running_o(running_o), .proc_count_o(proc_count_o),
        .page_drop_o(page_drop_o), .ctx_base_o(ctx_base_o), .ctx_limit_o(ctx_limit_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: slot table plus the last scheduled pid.
    logic        model_valid [NPROC];
    logic [31:0] model_pc    [NPROC];
    logic [15:0] model_base  [NPROC];
    logic [15:0] model_limit [NPROC];
    int          model_cur;
    logic [31:0] exp_q[$];
    bit          chk_en = 1'b0;
    bit          prev_cv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NPROC; i++) begin
            model_valid[i] = 1'b0;
            model_pc[i]    = '0;
            model_base[i]  = '0;
            model_limit[i] = '0;
        end
        model_cur = NPROC - 1;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NPROC; i++) if (model_valid[i]) n++;
        return n;
    endfunction

    function automatic int model_next();
        for (int k = 1; k <= NPROC; k++) begin
            if (model_valid[(model_cur + k) % NPROC]) return (model_cur + k) % NPROC;
        end
        return -1;
    endfunction

    function automatic bit model_alloc(input logic [31:0] p);
        for (int i = 0; i < NPROC; i++) begin
            if (!model_valid[i]) begin
                model_valid[i] = 1'b1;
                model_base[i]  = p[31:16];
                model_limit[i] = p[15:0];
                model_pc[i]    = {16'h0000, p[31:16]};
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Scoreboard: per-cycle invariants and every new restore against the model.
    always @(negedge clk) begin : compare
        int e;
        if (chk_en) begin
            chk("excl", 32'($onehot0({ctx_valid_o, save_req_o, running_o})), 32'd1);
            chk("proc_count", 32'(proc_count_o), 32'(model_count()));
            if (ctx_valid_o && !prev_cv) begin
                e = model_next();
                if (e < 0) begin
                    chk("restore_none_valid", 32'd1, 32'd0);
                end else begin
                    chk("restore_pid", 32'(ctx_pid_o), 32'(e));
                    chk("restore_pc", ctx_pc_o, model_pc[e]);
                    chk("restore_base", 32'(ctx_base_o), 32'(model_base[e]));
                    chk("restore_limit", 32'(ctx_limit_o), 32'(model_limit[e]));
                    model_cur = e;
                    if (exp_q.size() > 0) chk("restore_order", 32'(ctx_pid_o), exp_q.pop_front());
                end
            end
            if (running_o) chk("run_pid", 32'(ctx_pid_o), 32'(model_cur));
        end
        prev_cv = ctx_valid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic page_write(input logic [31:0] p, output bit dropped);
        bit exp_drop;
        page_in_i = p;
        page_wr_i = 1'b1;
        @(posedge clk);
        exp_drop = model_alloc(p);
        #1;
        page_wr_i = 1'b0;
        dropped   = page_drop_o;
        chk("page_drop", 32'(page_drop_o), 32'(exp_drop));
    endtask

    task automatic wait_restore();
        int n = 0;
        while (!ctx_valid_o && n < 300) begin
            tick();
            n++;
        end
        chk("restore_timeout", 32'(ctx_valid_o), 32'd1);
    endtask

    task automatic ack_restore();
        ctx_ack_i = 1'b1;
        tick();
        ctx_ack_i = 1'b0;
    endtask

    task automatic do_yield();
        yield_i = 1'b1;
        tick();
        yield_i = 1'b0;
    endtask

    task automatic serve_save(input logic [31:0] pc, input int delay);
        int n = 0;
        while (!save_req_o && n < 300) begin
            tick();
            n++;
        end
        chk("save_timeout", 32'(save_req_o), 32'd1);
        if (delay > 0) begin
            repeat (delay) tick();
            chk("save_held", 32'(save_req_o), 32'd1);
        end
        cpu_pc_i   = pc;
        save_ack_i = 1'b1;
        @(posedge clk);
        model_pc[model_cur] = pc;
        #1;
        save_ack_i = 1'b0;
        cpu_pc_i   = '0;
    endtask

    task automatic do_exit(input bit with_yield);
        proc_exit_i = 1'b1;
        yield_i     = with_yield;
        @(posedge clk);
        model_valid[model_cur] = 1'b0;
        #1;
        proc_exit_i = 1'b0;
        yield_i     = 1'b0;
    endtask

    task automatic exit_and_write(input logic [31:0] p);
        bit exp_drop;
        proc_exit_i = 1'b1;
        page_wr_i   = 1'b1;
        page_in_i   = p;
        @(posedge clk);
        exp_drop = model_alloc(p);
        model_valid[model_cur] = 1'b0;
        #1;
        proc_exit_i = 1'b0;
        page_wr_i   = 1'b0;
        chk("exit_write_drop", 32'(page_drop_o), 32'(exp_drop));
    endtask

    task automatic slice_end();
`ifdef SCHED_PREEMPT_EN
        int n = 0;
        while (running_o && n < 300) begin
            n++;
            tick();
        end
        chk("quantum_len", 32'(n), 32'(QUANTUM));
        chk("save_after_expiry", 32'(save_req_o), 32'd1);
`else
        repeat (100) tick();
        chk("coop_still_running", 32'(running_o), 32'd1);
        chk("coop_no_save", 32'(save_req_o), 32'd0);
        do_yield();
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctx_valid"}, 32'(ctx_valid_o), 32'd0);
        chk({tag, "_ctx_pid"}, 32'(ctx_pid_o), 32'd0);
        chk({tag, "_ctx_pc"}, ctx_pc_o, 32'd0);
        chk({tag, "_save_req"}, 32'(save_req_o), 32'd0);
        chk({tag, "_running"}, 32'(running_o), 32'd0);
        chk({tag, "_proc_count"}, 32'(proc_count_o), 32'd0);
        chk({tag, "_page_drop"}, 32'(page_drop_o), 32'd0);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
    endtask

    initial begin : main
        bit d;
        reset = 1'b1;
        run_en_i = 1'b0; page_wr_i = 1'b0; page_in_i = '0; proc_exit_i = 1'b0;
        yield_i = 1'b0; ctx_ack_i = 1'b0; save_ack_i = 1'b0; cpu_pc_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset  = 1'b0;
        chk_en = 1'b1;
        tick();

        // Three processes, full round-robin with saves.
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
        page_write(32'h0000_0010, d);
        page_write(32'h0020_0030, d);
        page_write(32'h0040_0050, d);
        chk("count_3", 32'(proc_count_o), 32'd3);
        run_en_i = 1'b1;
        wait_restore();
        chk("first_pid", 32'(ctx_pid_o), 32'd0);
        chk("first_pc", ctx_pc_o, 32'h0);
        tick();
        tick();
        chk("restore_held", 32'(ctx_valid_o), 32'd1);
        chk("restore_pc_held", ctx_pc_o, 32'h0);
        ack_restore();
        slice_end();
        serve_save(32'h5, 1);
        wait_restore();
        chk("second_pid", 32'(ctx_pid_o), 32'd1);
        ack_restore();
        slice_end();
        serve_save(32'h21, 0);
        wait_restore();
        chk("third_pid", 32'(ctx_pid_o), 32'd2);
        ack_restore();
        slice_end();
        serve_save(32'h41, 0);
        wait_restore();
        chk("resume_pid", 32'(ctx_pid_o), 32'd0);
        chk("resume_pc", ctx_pc_o, 32'h5);
        ack_restore();
        slice_end();
        serve_save(32'h6, 0);

        // Exit coincident with yield (and expiry when preemptive): exit wins.
        wait_restore();
        chk("slot1_pc", ctx_pc_o, 32'h21);
        ack_restore();
`ifdef SCHED_PREEMPT_EN
        repeat (QUANTUM - 1) tick();
`else
        repeat (5) tick();
`endif
        do_exit(1'b1);
        chk("exit_no_save", 32'(save_req_o), 32'd0);
        chk("count_2", 32'(proc_count_o), 32'd2);
        wait_restore();
        chk("after_exit_pid", 32'(ctx_pid_o), 32'd2);
        chk("after_exit_pc", ctx_pc_o, 32'h41);
        ack_restore();
        tick();
        do_exit(1'b0);
        wait_restore();
        chk("last_pid", 32'(ctx_pid_o), 32'd0);
        chk("last_pc", ctx_pc_o, 32'h6);
        ack_restore();
        do_exit(1'b0);
        repeat (3) tick();
        check_all_zero("all_exit");

        // Single process: yield reselects itself.
        exp_q = '{32'd0, 32'd0};
        page_write(32'h0100_01FF, d);
        wait_restore();
        chk("single_pc", ctx_pc_o, 32'h100);
        ack_restore();
        repeat (3) tick();
        do_yield();
        chk("yield_save", 32'(save_req_o), 32'd1);
        serve_save(32'h123, 0);
        wait_restore();
        chk("single_reselect", 32'(ctx_pid_o), 32'd0);
        chk("single_resume_pc", ctx_pc_o, 32'h123);
        ack_restore();
        tick();
        do_exit(1'b0);
        repeat (3) tick();
        chk("single_idle_running", 32'(running_o), 32'd0);
        chk("single_idle_state", 32'(state_o), 32'd0);

        // Table overflow: ninth page dropped.
        run_en_i = 1'b0;
        for (int i = 0; i < 9; i++) page_write({16'(i * 256), 16'(i * 256 + 255)}, d);
        chk("drop_9th", 32'(d), 32'd1);
        chk("count_full", 32'(proc_count_o), 32'd8);
        tick();
        chk("drop_pulse_end", 32'(page_drop_o), 32'd0);

        // Reset in the middle of a save handshake.
        run_en_i = 1'b1;
        wait_restore();
        chk("full_pid", 32'(ctx_pid_o), 32'd1);
        chk("full_pc", ctx_pc_o, 32'h100);
        ack_restore();
        tick();
        do_yield();
        chk("pre_reset_save", 32'(save_req_o), 32'd1);
        chk_en = 1'b0;
        reset  = 1'b1;
        tick();
        check_all_zero("mid_save_reset");
        model_reset();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Slot freed by exit is not reused by a same-cycle page write.
        run_en_i = 1'b0;
        page_write(32'h0200_02FF, d);
        page_write(32'h0300_03FF, d);
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd1};
        run_en_i = 1'b1;
        wait_restore();
        chk("post_reset_pid", 32'(ctx_pid_o), 32'd0);
        chk("post_reset_pc", ctx_pc_o, 32'h200);
        ack_restore();
        tick();
        exit_and_write(32'h0400_04FF);
        chk("same_cycle_count", 32'(proc_count_o), 32'd2);
        wait_restore();
        chk("reuse_prev_pc", ctx_pc_o, 32'h300);
        ack_restore();
        tick();
        do_yield();
        serve_save(32'h333, 0);
        wait_restore();
        chk("reuse_pid", 32'(ctx_pid_o), 32'd2);
        chk("reuse_pc", ctx_pc_o, 32'h400);
        chk("reuse_limit", 32'(ctx_limit_o), 32'h04FF);
        ack_restore();
        do_exit(1'b0);
        wait_restore();
        chk("wrap_pc", ctx_pc_o, 32'h333);
        ack_restore();
        do_exit(1'b0);
        repeat (3) tick();
        check_all_zero("final");

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_scheduler.md
PROC_SCHEDULER -- requirements
Module: proc_scheduler

Interface
REQ-001 Parameter NPROC, default 8, number of process-table slots; PID_W = clog2(NPROC).
REQ-002 Parameter QUANTUM, default 64, time slice in clk cycles per process (QUANTUM >= 2).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 run_en  input  1  scheduling permitted (high once BIOS loading is finished).
REQ-006 page_wr  input  1  one-cycle pulse: register new process.
REQ-007 page_in  input  32  process page: [31:16] base address, [15:0] end address.
REQ-008 proc_exit  input  1  running process executed HALT; remove it.
REQ-009 yield  input  1  running process voluntarily gives up CPU.
REQ-010 ctx_ack  input  1  CPU has loaded ctx_pc.
REQ-011 save_ack  input  1  cpu_pc is valid for the save.
REQ-012 cpu_pc  input  32  PC of running process, sampled when save_ack is high.
REQ-013 ctx_valid  output  1  restore request; ctx_pid/ctx_pc valid.
REQ-014 ctx_pid  output  PID_W  slot being restored or running.
REQ-015 ctx_pc  output  32  PC to load into CPU.
REQ-016 save_req  output  1  request CPU PC for context save.
REQ-017 running  output  1  a process owns the CPU.
REQ-018 proc_count  output  PID_W+1  number of valid slots.
REQ-019 page_drop  output  1  one-cycle pulse: page_wr rejected, table full.

Function
REQ-020 Table per slot: valid, base[15:0], limit[15:0], saved_pc[31:0].
REQ-021 page_wr SHALL allocate lowest-index free slot next cycle: valid=1, base/limit from page_in, saved_pc = zero-extended base.
REQ-022 page_wr with all slots valid SHALL pulse page_drop one cycle after and leave the table unchanged.
REQ-023 page_wr is accepted in every FSM state; a slot freed by proc_exit in the same cycle is not reusable until the following cycle.
REQ-024 FSM states: IDLE, SELECT, RESTORE, RUN, SAVE.
REQ-025 IDLE -> SELECT when run_en=1 and proc_count>0; otherwise remain.
REQ-026 SELECT (one cycle): next valid slot searched round-robin from ctx_pid+1 with wrap; current slot is reselected only if it is the sole valid one; none valid -> IDLE.
REQ-027 RESTORE: ctx_valid=1, ctx_pc=saved_pc[ctx_pid], held stable until ctx_ack; on ctx_ack -> RUN, quantum counter loaded with QUANTUM-1.
REQ-028 RUN: running=1; counter decrements each cycle, saturating at 0.
REQ-029 RUN, proc_exit=1: clear valid[ctx_pid], no save, -> SELECT.
REQ-030 RUN, yield=1 or quantum expiry (counter==0): -> SAVE.
REQ-031 Simultaneous proc_exit with yield/expiry: proc_exit wins.
REQ-032 SAVE: save_req=1 until save_ack; on save_ack store cpu_pc into saved_pc[ctx_pid], -> SELECT.
REQ-033 run_en falling: takes effect only from IDLE/SELECT (SELECT -> IDLE); RESTORE/RUN/SAVE complete normally.
REQ-034 ctx_valid, save_req, running are mutually exclusive.
REQ-035 proc_count updates the cycle after allocation or exit.

Reset
REQ-036 Reset SHALL clear all valid bits, state=IDLE, ctx_pid=NPROC-1 (first SELECT picks slot 0), counter=0, all outputs 0, at any time including mid-handshake.

Configuration
REQ-037 Macro SCHED_PREEMPT_EN defined: quantum expiry preempts per REQ-030.
REQ-038 Macro undefined: no quantum counter; switching only on yield or proc_exit (cooperative).

Structure
REQ-039 Shared package: state enum, page field positions (BASE 31:16, END 15:0), default NPROC/QUANTUM.
REQ-040 One sub-module rr_pick: combinational round-robin selector (valid mask, start index -> pid, found).

Verification
REQ-041 Reset, 3 page_wr (0x0000_0010, 0x0020_0030, 0x0040_0050), run_en=1 -> ctx_valid with ctx_pid=0, ctx_pc=0x0; proc_count=3.
REQ-042 Ack every request, QUANTUM=64, save_ack with cpu_pc=0x5 -> preempt after 64 RUN cycles; order 0,1,2,0; slot 0 restores ctx_pc=0x5.
REQ-043 proc_exit in slot 1 same cycle as expiry -> no save_req, proc_count 3->2, next ctx_pid=2.
REQ-044 9 page_wr with NPROC=8 -> 9th gives page_drop pulse, proc_count=8.
REQ-045 Single process, yield -> SAVE then SELECT reselects pid 0; all exit -> IDLE, running=0.
REQ-046 Reset asserted while save_req high -> next cycle all outputs 0, proc_count=0.
